// File: rtl/dmem_ctrl.sv
// Byte-serial data-memory controller: commits stores from the reorder buffer and services
// loads from the load/store buffer over an 8-bit RAM port, with UART back-pressure and flush.
module dmem_ctrl #(
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      rob_store_valid,
    input  logic [1:0]                rob_store_type,
    input  logic [31:0]               rob_store_addr,
    input  logic [31:0]               rob_store_value,
    input  logic                      lsb_load_valid,
    input  logic [2:0]                lsb_load_type,
    input  logic [31:0]               lsb_load_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_load_rob_id,
    input  logic                      flush_in,
    input  logic                      io_buffer_full,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    output logic                      busy_out,
    output logic                      result_valid,
    output logic [ROB_SIZE_WIDTH-1:0] result_rob_id,
    output logic [31:0]               result_value
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    logic [1:0]                state_r;
    logic [1:0]                cnt_r;
    logic [1:0]                last_r;
    logic [31:0]               addr_r;
    logic [31:0]               value_r;
    logic [31:0]               data_r;
    logic [2:0]                ld_type_r;
    logic [ROB_SIZE_WIDTH-1:0] rob_id_r;

    logic [1:0]  next_cnt_s;
    logic [31:0] cur_addr_s;
    logic [31:0] next_addr_s;
    logic [31:0] load_data_s;

    function automatic logic [1:0] store_last(input logic [1:0] t);
        case (t)
            2'b00:   store_last = 2'd0;
            2'b01:   store_last = 2'd1;
            default: store_last = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] load_last(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   load_last = 2'd0;
            2'b01:   load_last = 2'd1;
            default: load_last = 2'd3;
        endcase
    endfunction

    // UART transmit registers; writes there must wait while its FIFO is full
    function automatic logic is_io(input logic [31:0] a);
        is_io = (a == 32'h0003_0000) || (a == 32'h0003_0004);
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] v, input logic [1:0] k);
        case (k)
            2'd0:    pick_byte = v[7:0];
            2'd1:    pick_byte = v[15:8];
            2'd2:    pick_byte = v[23:16];
            default: pick_byte = v[31:24];
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'd0, d[7:0]};
            3'b101:  extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign busy_out    = (state_r != ST_IDLE);
    assign next_cnt_s  = cnt_r + 2'd1;
    assign cur_addr_s  = addr_r + {30'd0, cnt_r};
    assign next_addr_s = addr_r + {30'd0, next_cnt_s};

    // Merge the byte arriving this cycle into the partially assembled load word
    always_comb begin
        load_data_s = data_r;
        case (cnt_r)
            2'd0:    load_data_s[7:0]   = mem_din;
            2'd1:    load_data_s[15:8]  = mem_din;
            2'd2:    load_data_s[23:16] = mem_din;
            default: load_data_s[31:24] = mem_din;
        endcase
    end

    // Controller FSM; mem_wr low in STORE means the current byte still has to be (re)issued
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 2'd0;
            last_r        <= 2'd0;
            addr_r        <= 32'd0;
            value_r       <= 32'd0;
            data_r        <= 32'd0;
            ld_type_r     <= 3'd0;
            rob_id_r      <= '0;
            mem_wr        <= 1'b0;
            mem_a         <= 32'd0;
            mem_dout      <= 8'd0;
            result_valid  <= 1'b0;
            result_rob_id <= '0;
            result_value  <= 32'd0;
        end else begin
            result_valid <= 1'b0;
            if (!rdy_in) begin
                mem_wr <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rob_store_valid) begin
                            state_r  <= ST_STORE;
                            cnt_r    <= 2'd0;
                            last_r   <= store_last(rob_store_type);
                            addr_r   <= rob_store_addr;
                            value_r  <= rob_store_value;
                            mem_a    <= rob_store_addr;
                            mem_dout <= rob_store_value[7:0];
                            mem_wr   <= !(is_io(rob_store_addr) && io_buffer_full);
                        end else if (lsb_load_valid && !flush_in) begin
                            state_r   <= ST_LOAD;
                            cnt_r     <= 2'd0;
                            last_r    <= load_last(lsb_load_type);
                            addr_r    <= lsb_load_addr;
                            ld_type_r <= lsb_load_type;
                            rob_id_r  <= lsb_load_rob_id;
                            data_r    <= 32'd0;
                            mem_a     <= lsb_load_addr;
                            mem_wr    <= 1'b0;
                        end else begin
                            mem_wr <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        mem_wr <= 1'b0;
                        if (flush_in) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 2'd0;
                        end else if (cnt_r == last_r) begin
                            state_r       <= ST_IDLE;
                            cnt_r         <= 2'd0;
                            result_valid  <= 1'b1;
                            result_rob_id <= rob_id_r;
                            result_value  <= extend(load_data_s, ld_type_r);
                        end else begin
                            data_r <= load_data_s;
                            cnt_r  <= next_cnt_s;
                            mem_a  <= next_addr_s;
                        end
                    end
                    ST_STORE: begin
                        if (mem_wr && (cnt_r == last_r)) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 2'd0;
                            mem_wr  <= 1'b0;
                        end else if (mem_wr) begin
                            cnt_r    <= next_cnt_s;
                            mem_a    <= next_addr_s;
                            mem_dout <= pick_byte(value_r, next_cnt_s);
                            mem_wr   <= !(is_io(next_addr_s) && io_buffer_full);
                        end else begin
                            mem_a    <= cur_addr_s;
                            mem_dout <= pick_byte(value_r, cnt_r);
                            mem_wr   <= !(is_io(cur_addr_s) && io_buffer_full);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 2'd0;
                        mem_wr  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a byte RAM model and a write log.
module tb_dmem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, io_buffer_full;
    logic        rob_store_valid, lsb_load_valid;
    logic [1:0]  rob_store_type;
    logic [31:0] rob_store_addr, rob_store_value, lsb_load_addr;
    logic [2:0]  lsb_load_type;
    logic [3:0]  lsb_load_rob_id;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a, result_value;
    logic        mem_wr, busy_out, result_valid;
    logic [3:0]  result_rob_id;

    logic [7:0]  ram [0:1023];
    logic [31:0] log_a[$];
    logic [7:0]  log_d[$];
    int          log_c[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_ctrl #(.ROB_SIZE_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_store_valid(rob_store_valid), .rob_store_type(rob_store_type),
        .rob_store_addr(rob_store_addr), .rob_store_value(rob_store_value),
        .lsb_load_valid(lsb_load_valid), .lsb_load_type(lsb_load_type),
        .lsb_load_addr(lsb_load_addr), .lsb_load_rob_id(lsb_load_rob_id),
        .flush_in(flush_in), .io_buffer_full(io_buffer_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy_out(busy_out),
        .result_valid(result_valid), .result_rob_id(result_rob_id), .result_value(result_value)
    );

    always #5 clk_in = ~clk_in;

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (mem_wr === 1'b1) begin
            ram[mem_a[9:0]] <= mem_dout;
            log_a.push_back(mem_a);
            log_d.push_back(mem_dout);
            log_c.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a[9:0]] <= v;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic issue_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] v);
        rob_store_valid = 1'b1;
        rob_store_type  = t;
        rob_store_addr  = a;
        rob_store_value = v;
        step();
        rob_store_valid = 1'b0;
    endtask

    // Holds the load request until a result appears; k = edges from request to result
    task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [3:0] id,
                            output int k, output logic [31:0] v, output logic [3:0] rid);
        logic done;
        done = 1'b0;
        k = -1;
        v = 32'hxxxx_xxxx;
        rid = 4'hx;
        lsb_load_valid  = 1'b1;
        lsb_load_type   = t;
        lsb_load_addr   = a;
        lsb_load_rob_id = id;
        for (int i = 1; i <= 20; i++) begin
            if (!done) begin
                step();
                rob_store_valid = 1'b0;
                if (result_valid === 1'b1) begin
                    done = 1'b1;
                    k = i;
                    v = result_value;
                    rid = result_rob_id;
                end
            end
        end
        lsb_load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
        rob_store_valid = 1'b0; rob_store_type = 2'b00; rob_store_addr = 32'd0; rob_store_value = 32'd0;
        lsb_load_valid = 1'b0; lsb_load_type = 3'b000; lsb_load_addr = 32'd0; lsb_load_rob_id = 4'd0;
        step();
        step();
        rst_in = 1'b0;
        n_cmp += 7;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_out); end
        if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
        if (mem_a !== 32'd0) begin n_bad++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
        if (mem_dout !== 8'd0) begin n_bad++; $display("FAIL rst_mem_dout: got %h want 0", mem_dout); end
        if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", result_valid); end
        if (result_value !== 32'd0) begin n_bad++; $display("FAIL rst_value: got %h want 0", result_value); end
        if (result_rob_id !== 4'd0) begin n_bad++; $display("FAIL rst_rob_id: got %h want 0", result_rob_id); end
    endtask

    task automatic test_store_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log();
        issue_store(2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
        n_cmp++;
        if (busy_out !== 1'b1) begin n_bad++; $display("FAIL sw_busy0: got %b want 1", busy_out); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (busy_out !== (i < 4)) begin n_bad++; $display("FAIL sw_busy%0d: got %b want %b", i, busy_out, (i < 4)); end
        end
        n_cmp++;
        if (log_a.size() !== 4) begin n_bad++; $display("FAIL sw_count: got %0d want 4", log_a.size()); end
        if (log_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp += 3;
                if (log_a[i] !== 32'h100 + i) begin n_bad++; $display("FAIL sw_addr%0d: got %h want %h", i, log_a[i], 32'h100 + i); end
                if (log_d[i] !== exp_b[i]) begin n_bad++; $display("FAIL sw_data%0d: got %h want %h", i, log_d[i], exp_b[i]); end
                if (log_c[i] !== log_c[0] + i) begin n_bad++; $display("FAIL sw_cycle%0d: got %0d want %0d", i, log_c[i], log_c[0] + i); end
            end
        end
    endtask

    task automatic test_loads();
        int k;
        logic [31:0] v;
        logic [3:0] rid;
        poke(32'h20, 8'h80);
        poke(32'h40, 8'h34); poke(32'h41, 8'h92);
        poke(32'h200, 8'h11); poke(32'h201, 8'h22); poke(32'h202, 8'h33); poke(32'h203, 8'h44);
        poke(32'h3FE, 8'hA1); poke(32'h3FF, 8'hB2); poke(32'h000, 8'hC3); poke(32'h001, 8'hD4);
        run_load(3'b000, 32'h20, 4'd5, k, v, rid);
        n_cmp += 3;
        if (k !== 2) begin n_bad++; $display("FAIL lb_latency: got %0d want 2", k); end
        if (v !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_value: got %h want ffffff80", v); end
        if (rid !== 4'd5) begin n_bad++; $display("FAIL lb_rob_id: got %0d want 5", rid); end
        step();
        n_cmp++;
        if (result_valid !== 1'b0) begin n_bad++; $display("FAIL lb_pulse: got %b want 0", result_valid); end
        run_load(3'b100, 32'h20, 4'd6, k, v, rid);
        n_cmp += 3;
        if (k !== 2) begin n_bad++; $display("FAIL lbu_latency: got %0d want 2", k); end
        if (v !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_value: got %h want 00000080", v); end
        if (rid !== 4'd6) begin n_bad++; $display("FAIL lbu_rob_id: got %0d want 6", rid); end
        run_load(3'b001, 32'h40, 4'd1, k, v, rid);
        n_cmp += 2;
        if (k !== 3) begin n_bad++; $display("FAIL lh_latency: got %0d want 3", k); end
        if (v !== 32'hFFFF_9234) begin n_bad++; $display("FAIL lh_value: got %h want ffff9234", v); end
        run_load(3'b101, 32'h40, 4'd2, k, v, rid);
        n_cmp++;
        if (v !== 32'h0000_9234) begin n_bad++; $display("FAIL lhu_value: got %h want 00009234", v); end
        run_load(3'b010, 32'h200, 4'd3, k, v, rid);
        n_cmp += 3;
        if (k !== 5) begin n_bad++; $display("FAIL lw_latency: got %0d want 5", k); end
        if (v !== 32'h4433_2211) begin n_bad++; $display("FAIL lw_value: got %h want 44332211", v); end
        if (rid !== 4'd3) begin n_bad++; $display("FAIL lw_rob_id: got %0d want 3", rid); end
        run_load(3'b010, 32'hFFFF_FFFE, 4'd4, k, v, rid);
        n_cmp++;
        if (v !== 32'hD4C3_B2A1) begin n_bad++; $display("FAIL lw_wrap: got %h want d4c3b2a1", v); end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [31:0] v;
        logic [3:0] rid;
        clear_log();
        rob_store_valid = 1'b1; rob_store_type = 2'b00;
        rob_store_addr = 32'h300; rob_store_value = 32'h1234_565A;
        run_load(3'b010, 32'h200, 4'd7, k, v, rid);
        n_cmp += 4;
        if (k !== 7) begin n_bad++; $display("FAIL b2b_latency: got %0d want 7", k); end
        if (v !== 32'h4433_2211) begin n_bad++; $display("FAIL b2b_value: got %h want 44332211", v); end
        if (log_a.size() !== 1) begin n_bad++; $display("FAIL b2b_wr_count: got %0d want 1", log_a.size()); end
        if (log_d.size() == 1 && (log_a[0] !== 32'h300 || log_d[0] !== 8'h5A)) begin
            n_bad++; $display("FAIL b2b_wr: got %h/%h want 300/5a", log_a[0], log_d[0]);
        end
    endtask

    task automatic test_flush();
        int hits;
        lsb_load_valid = 1'b1; lsb_load_type = 3'b010; lsb_load_addr = 32'h200; lsb_load_rob_id = 4'd2;
        step();
        step();
        flush_in = 1'b1; lsb_load_valid = 1'b0;
        step();
        flush_in = 1'b0;
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL flush_ld_busy: got %b want 0", busy_out); end
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (result_valid === 1'b1) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin n_bad++; $display("FAIL flush_ld_result: got %0d pulses want 0", hits); end
        lsb_load_valid = 1'b1; flush_in = 1'b1;
        step();
        lsb_load_valid = 1'b0; flush_in = 1'b0;
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL flush_idle_block: got %b want 0", busy_out); end
        clear_log();
        issue_store(2'b10, 32'h100, 32'h0102_0304);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        step(); step(); step();
        n_cmp += 2;
        if (log_a.size() !== 4) begin n_bad++; $display("FAIL flush_st_count: got %0d want 4", log_a.size()); end
        if (log_d.size() == 4 && {log_d[0], log_d[1], log_d[2], log_d[3]} !== 32'h0403_0201) begin
            n_bad++; $display("FAIL flush_st_data: got %h%h%h%h want 04030201", log_d[0], log_d[1], log_d[2], log_d[3]);
        end
    endtask

    task automatic test_io_stall();
        clear_log();
        io_buffer_full = 1'b1;
        issue_store(2'b00, 32'h0003_0000, 32'h0000_0041);
        for (int i = 0; i < 3; i++) begin
            n_cmp += 2;
            if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL io_stall_wr%0d: got %b want 0", i, mem_wr); end
            if (busy_out !== 1'b1) begin n_bad++; $display("FAIL io_stall_busy%0d: got %b want 1", i, busy_out); end
            if (i == 2) io_buffer_full = 1'b0;
            step();
        end
        n_cmp += 3;
        if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL io_release_wr: got %b want 1", mem_wr); end
        if (mem_a !== 32'h0003_0000) begin n_bad++; $display("FAIL io_release_addr: got %h want 00030000", mem_a); end
        if (mem_dout !== 8'h41) begin n_bad++; $display("FAIL io_release_data: got %h want 41", mem_dout); end
        step();
        n_cmp += 2;
        if (busy_out !== 1'b0 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL io_done: got busy %b wr %b want 0 0", busy_out, mem_wr); end
        if (log_a.size() !== 1) begin n_bad++; $display("FAIL io_wr_count: got %0d want 1", log_a.size()); end
    endtask

    task automatic test_rdy_hold();
        lsb_load_valid = 1'b1; lsb_load_type = 3'b001; lsb_load_addr = 32'h40; lsb_load_rob_id = 4'd9;
        step();
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp += 3;
            if (busy_out !== 1'b1) begin n_bad++; $display("FAIL rdy_busy%0d: got %b want 1", i, busy_out); end
            if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rdy_valid%0d: got %b want 0", i, result_valid); end
            if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rdy_wr%0d: got %b want 0", i, mem_wr); end
        end
        rdy_in = 1'b1;
        step();
        n_cmp++;
        if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rdy_early: got %b want 0", result_valid); end
        step();
        lsb_load_valid = 1'b0;
        n_cmp += 3;
        if (result_valid !== 1'b1) begin n_bad++; $display("FAIL rdy_result_valid: got %b want 1", result_valid); end
        if (result_value !== 32'hFFFF_9234) begin n_bad++; $display("FAIL rdy_result_value: got %h want ffff9234", result_value); end
        if (result_rob_id !== 4'd9) begin n_bad++; $display("FAIL rdy_result_id: got %0d want 9", result_rob_id); end
    endtask

    task automatic test_reset_abort();
        clear_log();
        issue_store(2'b10, 32'h100, 32'hCAFE_F00D);
        step();
        rst_in = 1'b1;
        step();
        n_cmp += 3;
        if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL abort_wr: got %b want 0", mem_wr); end
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_out); end
        if (mem_a !== 32'd0) begin n_bad++; $display("FAIL abort_addr: got %h want 0", mem_a); end
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (log_a.size() !== 2) begin n_bad++; $display("FAIL abort_wr_count: got %0d want 2", log_a.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_back_to_back();
        test_flush();
        test_io_stall();
        test_rdy_hold();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
